// File: rtl/systolic_skew_feeder_if.sv
// Upstream operand handshake for the systolic skew feeder.
// The master drives one operand vector per beat; the slave (feeder) answers with ready.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
);

    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    logic                          in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic MAC array.
// Accepts one operand vector per beat and re-emits lane i delayed by i cycles so
// operands meet on the array diagonal, then zero-flushes the skew pipeline and
// pulses done once the last lane of the final beat has left the edge.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int MAX_BEATS  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    systolic_skew_feeder_if.slave              in_if,
    output logic [LANES*DATA_WIDTH-1:0]        lane_data_o,
    output logic [LANES-1:0]                   lane_valid_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [$clog2(MAX_BEATS+1)-1:0]     beat_count_o,
    output logic                               overrun_o
);

    localparam int CW         = $clog2(MAX_BEATS + 1);
    localparam int FW         = (LANES > 2) ? $clog2(LANES - 1) : 1;
    localparam int FLUSH_INIT = (LANES >= 2) ? (LANES - 2) : 0;
    localparam bit HAS_FLUSH  = (LANES > 1);
    localparam bit ONE_BEAT   = (MAX_BEATS == 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    // With a single lane there is nothing to drain, so the last beat goes straight to DONE.
    localparam state_t AFTER_LAST = HAS_FLUSH ? FLUSH : DONE;

    state_t          state_q;
    logic            inReady_q;
    logic            busy_q;
    logic            done_q;
    logic            overrun_q;
    logic [CW-1:0]   beatCount_q;
    logic [FW-1:0]   flushCnt_q;

    logic            accept;
    logic            atLimit;

    assign accept  = in_if.in_valid && inReady_q;
    // Accepting a beat while holding MAX_BEATS-1 reaches the transfer limit.
    assign atLimit = (beatCount_q == CW'(MAX_BEATS - 1));

    // Transfer control FSM; in_ready, busy and done are registered alongside the state.
    // done trails the DONE state by one cycle so it lands after the last lane has been shown.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            inReady_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            beatCount_q <= '0;
            flushCnt_q  <= '0;
        end else begin
            done_q <= (state_q == DONE);
            unique case (state_q)
                IDLE: begin
                    inReady_q <= 1'b1;
                    busy_q    <= 1'b0;
                    if (accept) begin
                        beatCount_q <= CW'(1);
                        overrun_q   <= 1'b0;
                        if (in_if.in_last || ONE_BEAT) begin
                            overrun_q  <= !in_if.in_last;
                            state_q    <= AFTER_LAST;
                            inReady_q  <= 1'b0;
                            busy_q     <= HAS_FLUSH;
                            flushCnt_q <= FW'(FLUSH_INIT);
                        end else begin
                            state_q <= STREAM;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beatCount_q <= beatCount_q + CW'(1);
                        if (in_if.in_last || atLimit) begin
                            overrun_q  <= !in_if.in_last;
                            state_q    <= AFTER_LAST;
                            inReady_q  <= 1'b0;
                            busy_q     <= HAS_FLUSH;
                            flushCnt_q <= FW'(FLUSH_INIT);
                        end
                    end
                end
                FLUSH: begin
                    inReady_q <= 1'b0;
                    if (flushCnt_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        flushCnt_q <= flushCnt_q - FW'(1);
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    inReady_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    inReady_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = inReady_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign overrun_o      = overrun_q;
    assign beat_count_o   = beatCount_q;

    // One delay line per lane: stage 0 captures the accepted operand (or a zero bubble)
    // and lane i adds i more stages, so every lane shifts every cycle with no stall.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_WIDTH:0] pipe_q [0:g];
        logic [DATA_WIDTH:0] capture_d;

        assign capture_d = accept ? {1'b1, in_if.in_data[g*DATA_WIDTH +: DATA_WIDTH]}
                                  : '0;

        // Shift the lane's skew line; the valid bit travels with its data.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j <= g; j++) begin
                    pipe_q[j] <= '0;
                end
            end else begin
                pipe_q[0] <= capture_d;
                for (int j = 1; j <= g; j++) begin
                    pipe_q[j] <= pipe_q[j-1];
                end
            end
        end

        assign lane_data_o[g*DATA_WIDTH +: DATA_WIDTH] = pipe_q[g][DATA_WIDTH-1:0];
        assign lane_valid_o[g]                         = pipe_q[g][DATA_WIDTH];
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Edge feeder for the systolic MAC array: the writer side of each PE's A_in/B_in operand interface.
- Accepts one operand vector per beat (one element per array row or column) over a valid/ready handshake.
- Emits each lane with a diagonal skew (lane i delayed i cycles) so operands meet correctly inside the array, then zero-flushes the pipeline and pulses done.
- One instance drives the A edge and one drives the B edge; both share in_valid/in_last so their bubbles stay aligned.

Parameters:
- DATA_WIDTH, 32, operand width per lane; matches the PE operand width.
- LANES, 4, number of array rows/columns fed; must be >= 1.
- MAX_BEATS, 16, maximum beats (reduction length K) per transfer; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  feeder can accept a beat.
- in_data  input  LANES*DATA_WIDTH  operand vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  1  marks the final beat of a transfer; sampled only on an accepted beat.
- lane_data  output  LANES*DATA_WIDTH  skewed operands to the array edge; same lane packing as in_data.
- lane_valid  output  LANES  per-lane flag: 1 = real operand, 0 = zero padding.
- busy  output  1  high in STREAM and FLUSH.
- done  output  1  one-cycle pulse when the transfer is fully drained.
- beat_count  output  $clog2(MAX_BEATS+1)  beats accepted in the current or most recent transfer.
- overrun  output  1  sticky; set if the MAX_BEATS limit forced termination; cleared when the next transfer starts.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0 (lane_data, lane_valid, in_ready, busy, done, beat_count, overrun), all delay-line stages 0, FSM in IDLE. in_ready rises on the first clock edge after rst deasserts.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE: in_ready=1. An accepted beat clears beat_count to 1 and clears overrun. Go to FLUSH if that beat is last, otherwise STREAM.
  - STREAM: in_ready=1. Each accepted beat increments beat_count. On an accepted beat with in_last=1, or when beat_count reaches MAX_BEATS, go to FLUSH. A MAX_BEATS cutoff without in_last sets overrun.
  - FLUSH: in_ready=0. Inject zero vectors for LANES-1 cycles (counter from LANES-2 down to 0). When LANES=1, FLUSH lasts 0 cycles and the FSM goes straight to DONE.
  - DONE: done=1 for exactly one cycle, in_ready=0, then return to IDLE.
- Stage-0 capture each cycle: the accepted in_data with valid bit 1. Otherwise (in_valid=0 in STREAM, or any FLUSH/IDLE/DONE cycle), zeros with valid bit 0.
- Skew: lane i output equals the stage-0 capture for lane i delayed by i further cycles. Latency from accept edge to lane_data lane i is 1+i cycles.
- Lane i uses an i-deep shift register of DATA_WIDTH+1 bits (data plus valid). The delay lines shift every cycle, with no stall.
- Bubbles: if in_valid=0 mid-STREAM, a zero/invalid diagonal propagates. Alignment across lanes is preserved and the bubble contributes 0 to PE accumulation.
- done timing: done asserts on the cycle after the final beat's last lane (lane LANES-1) has been presented on lane_data. After that, all lane_valid bits are 0.
- in_last outside an accepted beat is ignored. in_data is never registered unless the beat is accepted.
- Data is a pass-through; there is no arithmetic or width change.
- Asynchronous reset mid-transfer aborts immediately. Delay lines are cleared, no done pulse is issued, and the FSM returns to IDLE.

Test Plan:
- LANES=4, DATA_WIDTH=32. Beats {1,2,3,4} then {5,6,7,8}(last), back-to-back -> lane0 shows 1,5 at accept+1 and +2; lane3 shows 4,8 at accept+4 and +5. lane_valid matches the data. done at last-accept+5. beat_count=2. overrun=0.
- Same two beats with a 1-cycle in_valid gap between them -> every lane shows value, 0 (lane_valid 0), value. Lane i is offset by i cycles. beat_count=2.
- Single beat {9,9,9,9} with last from IDLE -> FSM goes to FLUSH; in_ready=0 for 3 FLUSH cycles plus DONE; lane3 outputs 9 at accept+4. done pulses once.
- MAX_BEATS=16, stream 16 beats with in_last never set -> forced FLUSH after the 16th accept. overrun=1, beat_count=16. overrun clears when the next transfer's first beat is accepted.
- Assert rst low mid-STREAM after 3 beats -> all outputs 0 immediately, asynchronously. No done pulse. A new transfer after release behaves as in the first scenario.
- in_valid=1 with in_last=1 during FLUSH -> beat is not accepted (in_ready=0), beat_count unchanged, last is ignored.
